// File: rtl/figuras_pkg.sv
// Shared definitions for the VGA clock display figure generators:
// screen geometry, field widths, default colours and ring FSM states.
package figuras_pkg;

  localparam int unsigned MAX_X   = 640;
  localparam int unsigned MAX_Y   = 480;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned COLOR_W = 8;
  localparam int unsigned BOUND_W = 4 * COORD_W;

  localparam logic [COLOR_W-1:0] DEF_COLOR_FILL   = 8'hAA;
  localparam logic [COLOR_W-1:0] DEF_COLOR_BORDER = 8'hFF;
  localparam logic [COLOR_W-1:0] DEF_COLOR_RING   = 8'hE0;
  localparam logic [COLOR_W-1:0] COLOR_BLACK      = 8'h00;

  typedef enum logic {
    ST_IDLE,
    ST_RING
  } ring_state_t;

endpackage

// File: rtl/generador_recuadros_ring_box_hit.sv
// Combinational hit/border test of one pixel against one rectangle.
// Bound layout: {xl, xr, yt, yb}, 10 bits each, MSB first.
module box_hit
  import figuras_pkg::*;
#(
  parameter int unsigned BORDER_W = 4
) (
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic [BOUND_W-1:0] bound,
  output logic               hit,
  output logic               border
);

  logic [COORD_W-1:0] xl, xr, yt, yb;
  logic [COORD_W:0]   bw;

  assign xl = bound[4*COORD_W-1:3*COORD_W];
  assign xr = bound[3*COORD_W-1:2*COORD_W];
  assign yt = bound[2*COORD_W-1:COORD_W];
  assign yb = bound[COORD_W-1:0];
  assign bw = (COORD_W+1)'(BORDER_W);

  // Inverted bounds can never satisfy both inequalities, so no special case is needed.
  // Border sums are widened by one bit so boxes near 1023 do not wrap.
  always_comb begin
    hit    = (xl <= pixel_x) && (pixel_x <= xr) && (yt <= pixel_y) && (pixel_y <= yb);
    border = hit && (({1'b0, pixel_x} < ({1'b0, xl} + bw)) ||
                     (({1'b0, pixel_x} + bw) > {1'b0, xr}) ||
                     ({1'b0, pixel_y} < ({1'b0, yt} + bw)) ||
                     (({1'b0, pixel_y} + bw) > {1'b0, yb}));
  end

endmodule

// File: rtl/generador_recuadros_ring.sv
// Box generator with alarm-ring border blink for the 640x480 VGA clock.
// Optional feature macro: GENERADOR_RING_EN (ring FSM, frame tick, counters).
module generador_recuadros_ring
  import figuras_pkg::*;
#(
  parameter int unsigned        NUM_BOX      = 3,
  parameter int unsigned        BORDER_W     = 4,
  parameter int unsigned        BLINK_FRAMES = 30,
  parameter int unsigned        RING_TOGGLES = 20,
  parameter int unsigned        RING_BOX     = 2,
  parameter logic [COLOR_W-1:0] COLOR_FILL   = DEF_COLOR_FILL,
  parameter logic [COLOR_W-1:0] COLOR_BORDER = DEF_COLOR_BORDER,
  parameter logic [COLOR_W-1:0] COLOR_RING   = DEF_COLOR_RING
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       video_on,
  input  logic [COORD_W-1:0]         pixel_x,
  input  logic [COORD_W-1:0]         pixel_y,
  input  logic [NUM_BOX*BOUND_W-1:0] box_bounds,
  input  logic                       ring_req,
  input  logic                       ring_stop,
  output logic                       ring_active,
  output logic                       graph_on,
  output logic [COLOR_W-1:0]         fig_RGB
);

  logic [NUM_BOX-1:0] hit;
  logic [NUM_BOX-1:0] border;
  logic               phase;

  for (genvar b = 0; b < NUM_BOX; b++) begin : g_box
    box_hit #(.BORDER_W(BORDER_W)) u_box_hit (
      .pixel_x (pixel_x),
      .pixel_y (pixel_y),
      .bound   (box_bounds[b*BOUND_W +: BOUND_W]),
      .hit     (hit[b]),
      .border  (border[b])
    );
  end

  logic       win_found;
  logic       win_border;
  logic [2:0] win_idx;

  // Priority select: scan downwards so the lowest hit index is assigned last.
  always_comb begin
    win_found  = 1'b0;
    win_border = 1'b0;
    win_idx    = '0;
    for (int unsigned b = NUM_BOX; b > 0; b--) begin
      if (hit[b-1]) begin
        win_found  = 1'b1;
        win_border = border[b-1];
        win_idx    = 3'(b - 1);
      end
    end
  end

  logic [COLOR_W-1:0] rgb_d;
  logic               graph_d;

  // Pixel colour for the current coordinates.
  always_comb begin
    rgb_d   = COLOR_BLACK;
    graph_d = 1'b0;
    if (video_on && win_found) begin
      graph_d = 1'b1;
      if (win_border)
        rgb_d = (phase && (win_idx == 3'(RING_BOX))) ? COLOR_RING : COLOR_BORDER;
      else
        rgb_d = COLOR_FILL;
    end
  end

  // Output registers: one pixel clock of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      fig_RGB  <= '0;
      graph_on <= 1'b0;
    end else begin
      fig_RGB  <= rgb_d;
      graph_on <= graph_d;
    end
  end

`ifdef GENERADOR_RING_EN
  ring_state_t        state_q, state_d;
  logic               phase_q, phase_d;
  logic [7:0]         frame_q, frame_d;
  logic [7:0]         tog_q, tog_d;
  logic [COORD_W-1:0] prev_y;
  logic               frame_tick;
  logic               unused_cfg;

  assign unused_cfg  = (MAX_X == 0);
  assign frame_tick  = (pixel_y == COORD_W'(MAX_Y)) && (prev_y != COORD_W'(MAX_Y));
  assign phase       = phase_q;
  assign ring_active = (state_q == ST_RING);

  // Ring state, counters and previous-line register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      frame_q <= '0;
      tog_q   <= '0;
      prev_y  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
      tog_q   <= tog_d;
      prev_y  <= pixel_y;
    end
  end

  // Ring next state: stop beats request, request (re)starts, ticks advance the blink.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    frame_d = frame_q;
    tog_d   = tog_q;
    if (ring_stop) begin
      state_d = ST_IDLE;
      phase_d = 1'b0;
      frame_d = '0;
      tog_d   = '0;
    end else if (ring_req) begin
      state_d = ST_RING;
      phase_d = 1'b1;
      frame_d = '0;
      tog_d   = '0;
    end else if ((state_q == ST_RING) && frame_tick) begin
      if (frame_q == 8'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        if ((tog_q + 8'd1) == 8'(RING_TOGGLES)) begin
          state_d = ST_IDLE;
          phase_d = 1'b0;
          tog_d   = '0;
        end else begin
          phase_d = ~phase_q;
          tog_d   = tog_q + 8'd1;
        end
      end else begin
        frame_d = frame_q + 8'd1;
      end
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg  = ring_req ^ ring_stop ^ (BLINK_FRAMES == 0) ^
                       (RING_TOGGLES == 0) ^ (MAX_X == 0) ^ (MAX_Y == 0);
  assign phase       = 1'b0;
  assign ring_active = 1'b0;
`endif

endmodule

// File: doc/generador_recuadros_ring.md
# generador_recuadros_ring

Parametrised box generator for the 640x480 VGA clock display: draws NUM_BOX runtime-positioned rectangles with a fill colour and a border of configurable thickness, and animates an "alarm ring" by blinking the border of one selected box for a fixed number of frames when the timer expires. It sits between the VGA sync generator (pixel_x/pixel_y/video_on) and the RGB mux, alongside the text generator. Outputs are registered.

## Interface
- NUM_BOX, 3: number of rectangles (1..8).
- BORDER_W, 4: border thickness in pixels (1..15).
- BLINK_FRAMES, 30: frames per blink half-period (1..255).
- RING_TOGGLES, 20: blink half-periods per ring event (1..255).
- RING_BOX, 2: index of the box whose border blinks.
- COLOR_FILL, 8'hAA: interior colour (RRRGGGBB).
- COLOR_BORDER, 8'hFF: border colour, idle or blink-off phase.
- COLOR_RING, 8'hE0: border colour of RING_BOX, blink-on phase.

- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- video_on  in  1  visible region flag.
- pixel_x, pixel_y  in  10 each  current pixel coordinates.
- box_bounds  in  NUM_BOX*40  per box b, bits [40b+39:40b] = {xl, xr, yt, yb}, 10 bits each.
- ring_req  in  1  one-cycle pulse: start ring.
- ring_stop  in  1  one-cycle pulse: abort ring.
- ring_active  out  1  high while ring FSM is not IDLE.
- graph_on  out  1  pixel belongs to any box.
- fig_RGB  out  8  pixel colour.

## Operation
- Hit: box b hit when xl<=pixel_x<=xr and yt<=pixel_y<=yb. xl>xr or yt>yb never hits.
- Border: hit and (x<xl+BORDER_W or x+BORDER_W>xr or y<yt+BORDER_W or y+BORDER_W>yb); all sums computed at 11 bits, no wrap. Otherwise interior.
- Priority: lowest hit index wins colour.
- Colour: video_on=0 -> 0, graph_on=0. Winner border -> COLOR_RING if winner==RING_BOX and phase=1, else COLOR_BORDER. Winner interior -> COLOR_FILL. No hit -> 0.
- Frame tick: one-cycle pulse when pixel_y==480 and previous registered pixel_y!=480.
- Ring FSM states IDLE, RING.
  - IDLE: ring_req -> RING, phase=1, frame_cnt=0, tog_cnt=0.
  - RING: on frame tick, frame_cnt++; when frame_cnt==BLINK_FRAMES-1 it clears, phase toggles, tog_cnt++; when tog_cnt reaches RING_TOGGLES on that tick -> IDLE, phase=0.
  - ring_stop in any state -> IDLE, phase=0, counters 0. ring_stop and ring_req same cycle: stop wins.
  - ring_req while RING: restart (phase=1, counters 0).
- ring_active = (state==RING).

## Timing
- Reset values: fig_RGB=0, graph_on=0, ring_active=0, state IDLE, phase=0, all counters 0, previous pixel_y register 0.
- Pixel path latency: exactly 1 clk; fig_RGB/graph_on at cycle n+1 reflect inputs at cycle n.
- FSM updates on the clock edge after ring_req/ring_stop; ring_active high the cycle after ring_req; colour change visible on the first pixel sampled after that edge.
- Phase changes only on frame ticks (during vertical blanking), so no tearing within a frame.
- Reset mid-ring returns to IDLE next edge; no further blink.
- box_bounds sampled every cycle, not latched; changes take effect at the next pixel.

## Configuration
- GENERADOR_RING_EN defined: ring FSM, frame-tick detector and counters built as above.
- Not defined: no FSM or counters; ring_req/ring_stop ignored, ring_active tied 0, phase constant 0 (RING_BOX border always COLOR_BORDER); box drawing unchanged.

## Structure
- Shared package figuras_pkg: MAX_X=640, MAX_Y=480, coordinate width 10, colour width 8, default colour constants, FSM state encoding.
- Sub-module box_hit (one per box via generate): inputs pixel coordinates, one 40-bit bound, BORDER_W; outputs hit, border. Purely combinational; registering stays in the top.

## Test plan
- Reset, boxes {160,479,64,255},{48,303,352,447},{336,591,352,447}; pixel (300,150) -> next cycle fig_RGB=AA, graph_on=1; (162,150) -> FF; (10,10) -> 00, graph_on=0.
- video_on=0 at (300,150) -> fig_RGB=00, graph_on=0.
- Overlap box0 {0,99,0,99}, box1 {50,149,50,149}; pixel (80,80) -> box0 interior AA; (120,120) -> box1 interior AA.
- Degenerate box xl=200, xr=100 -> never hits at any x.
- Ring, BLINK_FRAMES=2, RING_TOGGLES=3: ring_req -> ring_active=1 next cycle, box2 border E0; toggles to FF after 2 frame ticks, E0 after 4, ring_active=0 and border FF after 6.
- ring_req and ring_stop same cycle while RING -> IDLE; reset mid-ring -> all outputs reset values next cycle.
